fifo_rd_stream: RTL and testbench

- Reader-side adapter for the team's synchronous FF FIFOs with registered read data.
- Drives the FIFO pop interface (rd_en / empty / rd_data with fixed read latency) and presents the popped words downstream as a valid/ready stream.
- Uses a small credit-controlled skid buffer to sustain one word per cycle.
- There is no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 76 +++++++
 tb/tb_fifo_rd_stream.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO pop side and the downstream valid/ready stream.
// The adapter uses the master modport; the FIFO/consumer side uses slave.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 2
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    level;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_data, m_valid, level
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, level
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Reader-side adapter: pops a registered-read FIFO and re-presents the words
// as a valid/ready stream through a credit-controlled skid buffer. Pops are
// decided from registered occupancy only, so m_ready never reaches fifo_rd_en
// combinationally.
module fifo_rd_stream #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = RD_LAT + 2,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    fifo_rd_stream_if.master bus
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [RD_LAT-1:0] vld_p;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW:0]       occ;
    logic              capture;
    logic              xfer;
    logic              m_valid_c;

    // Credits in use: words held plus words still travelling through the FIFO read pipe.
    always_comb begin
        occ = {1'b0, count};
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + (CW+1)'(vld_p[i]);
        end
    end

    // Pop decision and stream outputs, all from registered state; data is forced to zero while empty.
    always_comb begin
        m_valid_c      = (count != '0);
        capture        = vld_p[RD_LAT-1];
        xfer           = m_valid_c && bus.m_ready;
        bus.fifo_rd_en = !rst && !bus.fifo_empty && (occ < DEPTH_C);
        bus.m_valid    = m_valid_c;
        bus.m_data     = m_valid_c ? mem[rd_ptr] : '0;
        bus.level      = count;
    end

    // Control state: in-flight pipe, pointers (explicit wrap for any DEPTH) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            vld_p[0] <= bus.fifo_rd_en;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            if (capture) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (xfer) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(capture) - CW'(xfer);
        end
    end

    // Skid buffer storage: capture the popped word when it lands on the read port.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= bus.fifo_rd_data;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream with a behavioural registered-read FIFO and an
// in-order scoreboard fed by the stimulus and drained by a monitor.
module tb_fifo_rd_stream;
    localparam int WIDTH  = 32;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 3;
    localparam int CW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_rd_stream_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    fifo_rd_stream #(
        .WIDTH (WIDTH),
        .RD_LAT(RD_LAT),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [WIDTH-1:0] src_mem [2048];
    int               wr_total = 0;
    int               rd_idx   = 0;
    int               out_idx  = 0;
    logic             tb_inf   = 1'b0;
    int               checks   = 0;
    int               errors   = 0;

    assign bus.fifo_empty = (rd_idx == wr_total);

    // Upstream FIFO: one-cycle registered read, flushed by the shared reset.
    always @(posedge clk) begin
        if (rst) begin
            rd_idx <= wr_total;
            tb_inf <= 1'b0;
        end else begin
            tb_inf <= bus.fifo_rd_en;
            if (bus.fifo_rd_en && rd_idx < wr_total) begin
                bus.fifo_rd_data <= src_mem[rd_idx];
                rd_idx           <= rd_idx + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        src_mem[wr_total] = d;
        wr_total++;
    endtask

    task automatic monitor();
        logic bad;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_idx = wr_total;
            end else begin
                bad = (bus.fifo_rd_en && bus.fifo_empty) ||
                      ((int'(bus.level) + int'(tb_inf)) > DEPTH);
                check("invariant", 32'(bad), 32'd0);
                if (bus.m_valid && bus.m_ready) begin
                    check("sb_pending", 32'(out_idx < wr_total), 32'd1);
                    if (out_idx < wr_total) begin
                        check("sb_order", bus.m_data, src_mem[out_idx]);
                    end
                    out_idx++;
                end
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(bus.m_valid), 32'd1);
    endtask

    initial begin
        int nvalid;
        int cyc;
        int start_idx;
        bus.m_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            check("rst_valid", 32'(bus.m_valid), 32'd0);
            check("rst_level", 32'(bus.level), 32'd0);
            check("rst_data", bus.m_data, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.m_ready = 1'b1;

        // Single word
        @(posedge clk); #1;
        push(32'hA5);
        @(negedge clk);
        check("single_pop", 32'(bus.fifo_rd_en), 32'd1);
        @(negedge clk);
        check("single_pop_once", 32'(bus.fifo_rd_en), 32'd0);
        check("single_early", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(bus.m_valid), 32'd1);
        check("single_data", bus.m_data, 32'hA5);
        check("single_level", 32'(bus.level), 32'd1);
        @(negedge clk);
        check("single_done", 32'(bus.m_valid), 32'd0);
        check("single_level0", 32'(bus.level), 32'd0);

        // Streaming 16 words
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push(32'(i));
        @(negedge clk);
        @(negedge clk);
        check("stream_fill", 32'(bus.m_valid), 32'd0);
        nvalid = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.m_valid) nvalid++;
        end
        check("stream_gapless", 32'(nvalid), 32'd16);
        @(negedge clk);
        check("stream_end", 32'(bus.m_valid), 32'd0);

        // Backpressure with 10 words available
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        start_idx = rd_idx;
        for (int i = 0; i < 10; i++) push(32'h40 + 32'(i));
        repeat (6) @(negedge clk);
        check("bp_pops", 32'(rd_idx - start_idx), 32'd3);
        check("bp_level", 32'(bus.level), 32'd3);
        check("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("bp_head", bus.m_data, 32'h40);
        @(negedge clk);
        check("bp_hold", bus.m_data, 32'h40);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        nvalid = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.m_valid) nvalid++;
        end
        check("bp_gapless", 32'(nvalid), 32'd10);
        @(negedge clk);
        check("bp_end", 32'(bus.m_valid), 32'd0);

        // Random ready over 1000 words
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) push(32'hC000_0000 + 32'(i * 3));
        cyc = 0;
        while (out_idx < wr_total && cyc < 20000) begin
            @(posedge clk); #1;
            bus.m_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        check("rand_drain", 32'(out_idx), 32'(wr_total));
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_level0", 32'(bus.level), 32'd0);

        // Reset mid-stream with two held and one in flight
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h70 + 32'(i));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_level", 32'(bus.level), 32'd2);
        check("mid_inflight", 32'(tb_inf), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid", 32'(bus.m_valid), 32'd0);
        check("mid_level0", 32'(bus.level), 32'd0);
        check("mid_data", bus.m_data, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_no_stale", 32'(bus.m_valid), 32'd0);
        @(posedge clk); #1;
        push(32'h3C);
        bus.m_ready = 1'b1;
        @(negedge clk);
        wait_valid("fresh");
        check("fresh_data", bus.m_data, 32'h3C);
        repeat (2) @(negedge clk);
        check("fresh_level0", 32'(bus.level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
